// File: rtl/pipe_valid_ctrl_pkg.sv
// Shared constants and types for the pipeline valid/load-enable controller.
// Provides stage indices, the per-cycle action encoding and the counter width.
package pipe_ctrl_pkg;

  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE
  } ctrl_action_t;

endpackage

// File: rtl/pipe_valid_ctrl_if.sv
// Hazard inputs and per-stage valid/load outputs of the pipeline controller.
// The master side raises hazards; the slave side is the controller itself.
interface pipe_valid_ctrl_if #(
  parameter int NUM_STAGES = 4
);
  import pipe_ctrl_pkg::*;

  logic                  i_mem_resp;
  logic                  dcache_stall;
  logic                  ldi_stall;
  logic                  br_taken;
  logic [NUM_STAGES-1:0] stage_valid;
  logic [NUM_STAGES-1:0] load_en;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output i_mem_resp, dcache_stall, ldi_stall, br_taken,
    input  stage_valid, load_en, flush_cnt, bubble_cnt
  );

  modport slave (
    input  i_mem_resp, dcache_stall, ldi_stall, br_taken,
    output stage_valid, load_en, flush_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipe_valid_ctrl_fetch_window_ctr.sv
// Fetch window counter: opens HOLD_CYCLES cycles of fetch after each
// instruction-memory response; a taken branch closes it immediately.
module fetch_window_ctr #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_mem_resp,
  input  logic hold,
  input  logic kill,
  output logic fetch_ok
);

  localparam int FW = $clog2(HOLD_CYCLES + 1);

  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;

  // A word arriving alongside a taken branch is wrong-path, so kill wins.
  always_comb begin
    fcnt_d = fcnt_q;
    if (kill) begin
      fcnt_d = '0;
    end else if (i_mem_resp) begin
      fcnt_d = FW'(HOLD_CYCLES);
    end else if (!hold && (fcnt_q != '0)) begin
      fcnt_d = fcnt_q - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fetch_ok = (fcnt_q != '0);

endmodule

// File: rtl/pipe_valid_ctrl.sv
// Per-stage valid and load-enable controller with freeze/flush/bubble priority.
// Optional flush/bubble performance counters are built under PIPE_VALID_PERF_EN.
module pipe_valid_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_DEPTH  = 2,
  parameter int BUBBLE_STAGE = 1,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipe_valid_ctrl_if.slave bus
);

  if (NUM_STAGES < 2 || FLUSH_DEPTH < 1 || FLUSH_DEPTH >= NUM_STAGES ||
      BUBBLE_STAGE < 1 || BUBBLE_STAGE >= NUM_STAGES || HOLD_CYCLES < 1) begin : g_bad_param
    $error("pipe_valid_ctrl: illegal parameter combination");
  end

  ctrl_action_t          action;
  logic                  fetch_ok;
  logic [NUM_STAGES-1:0] sv_q;
  logic [NUM_STAGES-1:0] sv_d;
  logic [NUM_STAGES-1:0] sv_shl;
  logic [NUM_STAGES-1:0] load_en;

  fetch_window_ctr #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_fwin (
    .clk        (clk),
    .rst        (rst),
    .i_mem_resp (bus.i_mem_resp),
    .hold       (bus.dcache_stall),
    .kill       (bus.br_taken),
    .fetch_ok   (fetch_ok)
  );

  // Action decoder: deliberately blind to i_mem_resp so load_en has no path from it.
  always_comb begin
    action = ACT_ADVANCE;
    if (rst) begin
      action = ACT_RESET;
    end else if (bus.dcache_stall) begin
      action = ACT_FREEZE;
    end else if (bus.br_taken) begin
      action = ACT_FLUSH;
    end else if (bus.ldi_stall) begin
      action = ACT_BUBBLE;
    end
  end

  assign sv_shl = {sv_q[NUM_STAGES-2:0], 1'b0};

  always_comb begin
    sv_d    = sv_q;
    load_en = '1;
    unique case (action)
      ACT_RESET: begin
        sv_d = '0;
      end
      ACT_FREEZE: begin
        load_en = '0;
      end
      ACT_FLUSH: begin
        sv_d = sv_shl;
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i < FLUSH_DEPTH) sv_d[i] = 1'b0;
        end
      end
      ACT_BUBBLE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (i < BUBBLE_STAGE) begin
            sv_d[i]    = sv_q[i];
            load_en[i] = 1'b0;
          end else if (i == BUBBLE_STAGE) begin
            sv_d[i] = 1'b0;
          end else begin
            sv_d[i] = sv_shl[i];
          end
        end
      end
      default: begin
        sv_d = sv_shl | NUM_STAGES'(fetch_ok);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q <= '0;
    end else begin
      sv_q <= sv_d;
    end
  end

  assign bus.stage_valid = sv_q;
  assign bus.load_en     = load_en;

`ifdef PIPE_VALID_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_d;

  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (action == ACT_FLUSH)  flush_cnt_d  = sat_inc(flush_cnt_q);
    if (action == ACT_BUBBLE) bubble_cnt_d = sat_inc(bubble_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`else
  assign bus.flush_cnt  = '0;
  assign bus.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_valid_ctrl.sv
// Directed bench for pipe_valid_ctrl with a behavioural stage-valid model
// checked every cycle, plus literal per-scenario expectations.
module tb_pipe_valid_ctrl;

  localparam int NS  = 4;
  localparam int FD  = 2;
  localparam int BS  = 1;
  localparam int HC  = 2;
  localparam int ALL = (1 << NS) - 1;
`ifdef PIPE_VALID_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_valid_ctrl_if #(.NUM_STAGES(NS)) bif ();

  pipe_valid_ctrl #(
    .NUM_STAGES   (NS),
    .FLUSH_DEPTH  (FD),
    .BUBBLE_STAGE (BS),
    .HOLD_CYCLES  (HC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: valid bits as an integer mask, fetch window as a plain count.
  int m_sv, m_fcnt, m_fc, m_bc;

  always @(posedge clk) begin
    if (rst) begin
      m_sv <= 0; m_fcnt <= 0; m_fc <= 0; m_bc <= 0;
    end else begin
      if (bif.br_taken)          m_fcnt <= 0;
      else if (bif.i_mem_resp)   m_fcnt <= HC;
      else if (bif.dcache_stall) m_fcnt <= m_fcnt;
      else if (m_fcnt > 0)       m_fcnt <= m_fcnt - 1;

      if (bif.dcache_stall) begin
        m_sv <= m_sv;
      end else if (bif.br_taken) begin
        m_sv <= ((m_sv << 1) & ALL) & ~((1 << FD) - 1);
        if (m_fc < 65535) m_fc <= m_fc + 1;
      end else if (bif.ldi_stall) begin
        m_sv <= (m_sv & ((1 << BS) - 1)) | (((m_sv << 1) & ALL) & ~((1 << (BS + 1)) - 1));
        if (m_bc < 65535) m_bc <= m_bc + 1;
      end else begin
        m_sv <= ((m_sv << 1) & ALL) | ((m_fcnt != 0) ? 1 : 0);
      end
    end
  end

  function automatic int exp_le();
    if (rst)                   return ALL;
    if (bif.dcache_stall)      return 0;
    if (bif.br_taken)          return ALL;
    if (bif.ldi_stall)         return ALL & ~((1 << BS) - 1);
    return ALL;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_stage_valid", 32'(bif.stage_valid), 32'(m_sv));
      check("model_load_en", 32'(bif.load_en), 32'(exp_le()));
      check("model_flush_cnt", 32'(bif.flush_cnt), 32'(PERF != 0 ? m_fc : 0));
      check("model_bubble_cnt", 32'(bif.bubble_cnt), 32'(PERF != 0 ? m_bc : 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit resp, input bit ds, input bit ldi, input bit br);
    rst              = r;
    bif.i_mem_resp   = resp;
    bif.dcache_stall = ds;
    bif.ldi_stall    = ldi;
    bif.br_taken     = br;
  endtask

  task automatic lit(input string name, input int exp);
    check(name, 32'(bif.stage_valid), 32'(exp));
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
  endtask

  int seq1[6];
  int seq2[5];

  initial begin
    seq1 = '{1, 3, 6, 12, 8, 0};
    seq2 = '{3, 6, 12, 8, 0};

    // Reset state
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    chk_en = 1'b1;
    lit("rst_sv", 0);
    check("rst_load_en", 32'(bif.load_en), 32'hF);
    check("rst_flush_cnt", 32'(bif.flush_cnt), 0);
    check("rst_bubble_cnt", 32'(bif.bubble_cnt), 0);
    drive(0, 0, 0, 0, 0);

    // Single fetch response: two valid instructions flow through
    drive(0, 1, 0, 0, 0);
    tick();
    lit("t1_after_resp", 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      lit($sformatf("t1_seq%0d", i), seq1[i]);
    end

    // Same pulse with a 3-cycle data-cache freeze after the first valid
    do_reset();
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    lit("t2_first", 1);
    drive(0, 0, 1, 0, 0);
    #1;
    check("t2_freeze_le", 32'(bif.load_en), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lit($sformatf("t2_frozen%0d", i), 1);
      check($sformatf("t2_frozen_le%0d", i), 32'(bif.load_en), 0);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      lit($sformatf("t2_seq%0d", i), seq2[i]);
    end

    // Full pipe, taken branch while responses keep arriving
    do_reset();
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    lit("t3_full", 15);
    drive(0, 1, 0, 0, 1);
    tick();
    lit("t3_flushed", 12);
    check("t3_flush_cnt", 32'(bif.flush_cnt), 32'(PERF));
    drive(0, 0, 0, 0, 0);
    tick();
    lit("t3_fetch_closed", 8);

    // Load-use bubble into ID/EX
    do_reset();
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    lit("t4_pre", 7);
    drive(0, 0, 0, 1, 0);
    #1;
    check("t4_bubble_le", 32'(bif.load_en), 32'hE);
    tick();
    lit("t4_bubbled", 13);
    check("t4_bubble_cnt", 32'(bif.bubble_cnt), 32'(PERF));
    drive(0, 0, 0, 0, 0);
    tick();
    lit("t4_after", 11);

    // Freeze over simultaneous bubble and flush, then flush once
    do_reset();
    drive(0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    lit("t5_pre", 3);
    drive(0, 0, 1, 1, 1);
    #1;
    check("t5_all_le", 32'(bif.load_en), 0);
    tick();
    lit("t5_held", 3);
    drive(0, 0, 0, 1, 1);
    #1;
    check("t5_flush_le", 32'(bif.load_en), 32'hF);
    tick();
    lit("t5_flushed", 4);
    drive(0, 0, 0, 0, 0);
    #1;
    check("t5_flush_cnt", 32'(bif.flush_cnt), 32'(PERF));
    check("t5_bubble_cnt", 32'(bif.bubble_cnt), 0);
    tick();
    lit("t5_after", 8);

    // Reset mid-flight with an open fetch window
    do_reset();
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 1, 0, 1, 0);
    tick();
    lit("t6_bubbled", 13);
    drive(0, 1, 0, 0, 0);
    tick();
    lit("t6_pre", 11);
    drive(1, 1, 0, 1, 1);
    #1;
    check("t6_rst_le", 32'(bif.load_en), 32'hF);
    tick();
    lit("t6_rst", 0);
    check("t6_flush_cnt", 32'(bif.flush_cnt), 0);
    check("t6_bubble_cnt", 32'(bif.bubble_cnt), 0);
    drive(0, 0, 0, 0, 0);
    tick();
    lit("t6_fetch_closed", 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
